// File: rtl/alu_4_pkg.sv
// Shared definitions for the alu_4 command initiator: opcode map, FSM states, tag width.
package alu_4_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_NOTA = 4'd4,
      OP_NAND = 4'd5,
      OP_NOR  = 4'd6,
      OP_XOR  = 4'd7,
      OP_XNOR = 4'd8,
      OP_MUL  = 4'd9
   } op_e;

   localparam logic [3:0] OP_LAST = 4'd9;
   localparam int         TAG_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_LAST);
   endfunction

endpackage

// File: rtl/alu_4_initiator.sv
// Single-outstanding command master for the combinational alu_4: drives A/B/CTRL, samples Y after LAT cycles.
// Optional macro ALU_INIT_OPCHECK_EN: illegal opcodes are not driven and answer with rsp_err=1, rsp_y=0.
module alu_4_initiator
   import alu_4_pkg::*;
#(
   parameter int LAT   = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [3:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [7:0]       alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_y,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] LAT_V = 3'(LAT);

   state_e           state_r;
   state_e           next_state_s;
   logic [2:0]       wait_cnt_r;
   logic             cmd_ready_r;
   logic             rsp_valid_r;
   logic [3:0]       alu_a_r;
   logic [3:0]       alu_b_r;
   logic [3:0]       alu_ctrl_r;
   logic [7:0]       rsp_y_r;
   logic [TAG_W-1:0] rsp_tag_r;
   logic             rsp_err_r;
   logic [CNT_W-1:0] op_count_r;
   logic             accept_s;
   logic             handshake_s;
   logic             illegal_s;

   assign accept_s    = (state_r == ST_IDLE) && cmd_valid;
   assign handshake_s = (state_r == ST_RESP) && rsp_ready;

`ifdef ALU_INIT_OPCHECK_EN
   assign illegal_s = !op_is_legal(cmd_op);
`else
   assign illegal_s = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               next_state_s = ST_WAIT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 3'd0) begin
               next_state_s = ST_RESP;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State, operand, response and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= 3'd0;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         alu_a_r     <= 4'h0;
         alu_b_r     <= 4'h0;
         alu_ctrl_r  <= 4'h0;
         rsp_y_r     <= 8'h00;
         rsp_tag_r   <= {TAG_W{1'b0}};
         rsp_err_r   <= 1'b0;
         op_count_r  <= {CNT_W{1'b0}};
      end else begin
         state_r     <= next_state_s;
         cmd_ready_r <= (next_state_s == ST_IDLE);
         rsp_valid_r <= (next_state_s == ST_RESP);
         if (accept_s) begin
            rsp_tag_r <= cmd_tag;
            rsp_err_r <= illegal_s;
            // An illegal opcode keeps the ALU inputs and answers after a single cycle.
            if (illegal_s) begin
               wait_cnt_r <= 3'd0;
            end else begin
               wait_cnt_r <= LAT_V;
               alu_a_r    <= cmd_a;
               alu_b_r    <= cmd_b;
               alu_ctrl_r <= cmd_op;
            end
         end else if (state_r == ST_WAIT) begin
            if (wait_cnt_r == 3'd0) begin
               rsp_y_r <= rsp_err_r ? 8'h00 : alu_y;
            end else begin
               wait_cnt_r <= wait_cnt_r - 3'd1;
            end
         end
         if (handshake_s) begin
            op_count_r <= op_count_r + CNT_W'(1);
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_ctrl  = alu_ctrl_r;
   assign rsp_y     = rsp_y_r;
   assign rsp_tag   = rsp_tag_r;
   assign rsp_err   = rsp_err_r;
   assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_4_initiator.sv
// Self-checking bench: two initiators (LAT=0/CNT_W=16 and LAT=3/CNT_W=3) each driving a behavioural ALU stub.
module tb_alu_4_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid  [2];
   logic       cmd_ready_o[2];
   logic [3:0] cmd_a      [2];
   logic [3:0] cmd_b      [2];
   logic [3:0] cmd_op     [2];
   logic [1:0] cmd_tag    [2];
   logic [3:0] alu_a_o    [2];
   logic [3:0] alu_b_o    [2];
   logic [3:0] alu_ctrl_o [2];
   logic [7:0] alu_y      [2];
   logic       rsp_valid_o[2];
   logic       rsp_ready  [2];
   logic [7:0] rsp_y_o    [2];
   logic [1:0] rsp_tag_o  [2];
   logic       rsp_err_o  [2];
   logic [15:0] cnt0;
   logic [2:0]  cnt1;

   int errors = 0;
   int checks = 0;
   int exp_cnt[2];
   logic [11:0] exp_alu[2];

   always #5 clk = ~clk;

   // Reference ALU behaviour: operands zero-extended to 8 bits
   function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      logic [7:0] ea;
      logic [7:0] eb;
      ea = {4'h0, a};
      eb = {4'h0, b};
      case (op)
         4'd0:    return ea + eb;
         4'd1:    return ea - eb;
         4'd2:    return ea & eb;
         4'd3:    return ea | eb;
         4'd4:    return {4'h0, ~a};
         4'd5:    return {4'h0, ~(a & b)};
         4'd6:    return {4'h0, ~(a | b)};
         4'd7:    return ea ^ eb;
         4'd8:    return {4'h0, ~(a ^ b)};
         4'd9:    return ea * eb;
         default: return {a, b};
      endcase
   endfunction

   function automatic int lat_of(input int sel);
      return (sel == 0) ? 0 : 3;
   endfunction

   function automatic int cmask(input int sel);
      return (sel == 0) ? 65535 : 7;
   endfunction

   function automatic int get_cnt(input int sel);
      return (sel == 0) ? int'(cnt0) : int'(cnt1);
   endfunction

   function automatic bit op_driven(input logic [3:0] op);
`ifdef ALU_INIT_OPCHECK_EN
      return (op <= 4'd9);
`else
      return (op == op) ? 1'b1 : 1'b0;
`endif
   endfunction

   assign alu_y[0] = alu_ref(alu_a_o[0], alu_b_o[0], alu_ctrl_o[0]);
   assign alu_y[1] = alu_ref(alu_a_o[1], alu_b_o[1], alu_ctrl_o[1]);

   alu_4_initiator #(.LAT(0), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_o[0]),
      .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .cmd_tag(cmd_tag[0]),
      .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]), .alu_ctrl(alu_ctrl_o[0]), .alu_y(alu_y[0]),
      .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready[0]),
      .rsp_y(rsp_y_o[0]), .rsp_tag(rsp_tag_o[0]), .rsp_err(rsp_err_o[0]),
      .op_count(cnt0)
   );

   alu_4_initiator #(.LAT(3), .CNT_W(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_o[1]),
      .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .cmd_tag(cmd_tag[1]),
      .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]), .alu_ctrl(alu_ctrl_o[1]), .alu_y(alu_y[1]),
      .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready[1]),
      .rsp_y(rsp_y_o[1]), .rsp_tag(rsp_tag_o[1]), .rsp_err(rsp_err_o[1]),
      .op_count(cnt1)
   );

   // Drives one operation and measures the response; comparisons are left to the caller
   task automatic run_op(input int sel, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic [1:0] tag, input int hold, input bit early,
                         output int lat, output logic [7:0] y, output logic [1:0] rtag, output logic err,
                         output logic [11:0] alu_v, output bit cr_ok, output bit stable_ok);
      int guard;
      guard = 0;
      while (!cmd_ready_o[sel] && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      cmd_valid[sel] = 1'b1;
      cmd_a[sel]     = a;
      cmd_b[sel]     = b;
      cmd_op[sel]    = op;
      cmd_tag[sel]   = tag;
      rsp_ready[sel] = early;
      @(posedge clk); #1;
      cmd_valid[sel] = 1'b0;
      cmd_a[sel]     = 4'($urandom);
      cmd_b[sel]     = 4'($urandom);
      cmd_op[sel]    = 4'($urandom);
      cmd_tag[sel]   = 2'($urandom);
      lat   = 0;
      cr_ok = 1'b1;
      while (!rsp_valid_o[sel] && lat < 20) begin
         if (cmd_ready_o[sel]) cr_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      y         = rsp_y_o[sel];
      rtag      = rsp_tag_o[sel];
      err       = rsp_err_o[sel];
      alu_v     = {alu_a_o[sel], alu_b_o[sel], alu_ctrl_o[sel]};
      stable_ok = 1'b1;
      if (!early) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid_o[sel] || rsp_y_o[sel] !== y || rsp_tag_o[sel] !== rtag || rsp_err_o[sel] !== err ||
                {alu_a_o[sel], alu_b_o[sel], alu_ctrl_o[sel]} !== alu_v || cmd_ready_o[sel])
               stable_ok = 1'b0;
         end
         rsp_ready[sel] = 1'b1;
      end
      if (cmd_ready_o[sel]) cr_ok = 1'b0;
      @(posedge clk); #1;
      rsp_ready[sel] = 1'b0;
      if (rsp_valid_o[sel] || !cmd_ready_o[sel]) cr_ok = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         exp_cnt[s] = 0;
         exp_alu[s] = 12'h000;
         checks++;
         if ({cmd_ready_o[s], rsp_valid_o[s], alu_a_o[s], alu_b_o[s], alu_ctrl_o[s], rsp_y_o[s], rsp_tag_o[s], rsp_err_o[s]}
             !== {1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b alu=%h%h%h y=%h tag=%h err=%b, want rdy=1 vld=0 all zero",
                     s, cmd_ready_o[s], rsp_valid_o[s], alu_a_o[s], alu_b_o[s], alu_ctrl_o[s], rsp_y_o[s], rsp_tag_o[s], rsp_err_o[s]);
         end
         checks++;
         if (get_cnt(s) !== 0) begin
            errors++;
            $display("FAIL reset_count dut%0d: got %0d want 0", s, get_cnt(s));
         end
      end
   endtask

   task automatic test_directed();
      int lat; logic [7:0] y; logic [1:0] rtag; logic err; logic [11:0] alu_v; bit cr_ok; bit st_ok;
      run_op(0, 4'h5, 4'h3, 4'd0, 2'd2, 0, 1'b0, lat, y, rtag, err, alu_v, cr_ok, st_ok);
      exp_cnt[0] = exp_cnt[0] + 1; exp_alu[0] = {4'h5, 4'h3, 4'd0};
      checks++;
      if ({lat, y, rtag, err} !== {32'd1, 8'h08, 2'd2, 1'b0}) begin
         errors++; $display("FAIL add_lat0: got lat=%0d y=%h tag=%0d err=%b want lat=1 y=08 tag=2 err=0", lat, y, rtag, err);
      end
      checks++;
      if (get_cnt(0) !== 1) begin
         errors++; $display("FAIL add_count: got %0d want 1", get_cnt(0));
      end
      run_op(1, 4'hF, 4'hF, 4'd9, 2'd1, 1, 1'b0, lat, y, rtag, err, alu_v, cr_ok, st_ok);
      exp_cnt[1] = exp_cnt[1] + 1; exp_alu[1] = {4'hF, 4'hF, 4'd9};
      checks++;
      if ({lat, y, rtag, cr_ok} !== {32'd4, 8'hE1, 2'd1, 1'b1}) begin
         errors++; $display("FAIL mul_lat3: got lat=%0d y=%h tag=%0d rdy_ok=%b want lat=4 y=e1 tag=1 rdy_ok=1", lat, y, rtag, cr_ok);
      end
      run_op(0, 4'h7, 4'h3, 4'd1, 2'd3, 5, 1'b0, lat, y, rtag, err, alu_v, cr_ok, st_ok);
      exp_cnt[0] = exp_cnt[0] + 1; exp_alu[0] = {4'h7, 4'h3, 4'd1};
      checks++;
      if ({y, alu_v, st_ok, cr_ok} !== {8'h04, 12'h731, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sub_hold: got y=%h alu=%h stable=%b rdy_ok=%b want y=04 alu=731 stable=1 rdy_ok=1", y, alu_v, st_ok, cr_ok);
      end
      checks++;
      if (get_cnt(0) !== exp_cnt[0]) begin
         errors++; $display("FAIL sub_count: got %0d want %0d", get_cnt(0), exp_cnt[0]);
      end
   endtask

   task automatic test_reset_in_wait();
      bit seen;
      cmd_valid[1] = 1'b1; cmd_a[1] = 4'hC; cmd_b[1] = 4'hA; cmd_op[1] = 4'd2; cmd_tag[1] = 2'd3;
      @(posedge clk); #1;
      cmd_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0; exp_alu[0] = 12'h000; exp_alu[1] = 12'h000;
      checks++;
      if ({cmd_ready_o[1], rsp_valid_o[1], alu_a_o[1], alu_b_o[1], alu_ctrl_o[1], rsp_y_o[1], rsp_tag_o[1], rsp_err_o[1], cnt1}
          !== {1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 2'b00, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL rst_wait_state: got rdy=%b vld=%b alu=%h%h%h y=%h tag=%h cnt=%0d want rdy=1 vld=0 all zero",
                  cmd_ready_o[1], rsp_valid_o[1], alu_a_o[1], alu_b_o[1], alu_ctrl_o[1], rsp_y_o[1], rsp_tag_o[1], cnt1);
      end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (rsp_valid_o[1]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rst_wait_no_rsp: got rsp_valid seen=%b want 0", seen);
      end
   endtask

   task automatic test_illegal();
      int lat; logic [7:0] y; logic [1:0] rtag; logic err; logic [11:0] alu_v; bit cr_ok; bit st_ok;
      logic [7:0] ey; logic eerr; int elat;
      for (int s = 0; s < 2; s++) begin
         run_op(s, 4'h6, 4'h2, 4'hB, 2'd1, 0, 1'b0, lat, y, rtag, err, alu_v, cr_ok, st_ok);
         if (op_driven(4'hB)) begin
            exp_alu[s] = {4'h6, 4'h2, 4'hB}; ey = alu_ref(4'h6, 4'h2, 4'hB); eerr = 1'b0; elat = lat_of(s) + 1;
         end else begin
            ey = 8'h00; eerr = 1'b1; elat = 1;
         end
         exp_cnt[s] = (exp_cnt[s] + 1) & cmask(s);
         checks++;
         if ({y, err, alu_v, lat} !== {ey, eerr, exp_alu[s], elat}) begin
            errors++;
            $display("FAIL illegal_op dut%0d: got y=%h err=%b alu=%h lat=%0d want y=%h err=%b alu=%h lat=%0d",
                     s, y, err, alu_v, lat, ey, eerr, exp_alu[s], elat);
         end
         checks++;
         if (get_cnt(s) !== exp_cnt[s]) begin
            errors++; $display("FAIL illegal_count dut%0d: got %0d want %0d", s, get_cnt(s), exp_cnt[s]);
         end
      end
   endtask

   task automatic test_random();
      int lat; logic [7:0] y; logic [1:0] rtag; logic err; logic [11:0] alu_v; bit cr_ok; bit st_ok;
      logic [3:0] a; logic [3:0] b; logic [3:0] op; logic [1:0] tag; int s;
      logic [7:0] ey; logic eerr; int elat;
      for (int i = 0; i < 24; i++) begin
         s   = i % 2;
         a   = 4'($urandom); b = 4'($urandom); op = 4'($urandom); tag = 2'($urandom);
         run_op(s, a, b, op, tag, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, y, rtag, err, alu_v, cr_ok, st_ok);
         if (op_driven(op)) begin
            exp_alu[s] = {a, b, op}; ey = alu_ref(a, b, op); eerr = 1'b0; elat = lat_of(s) + 1;
         end else begin
            ey = 8'h00; eerr = 1'b1; elat = 1;
         end
         exp_cnt[s] = (exp_cnt[s] + 1) & cmask(s);
         checks++;
         if ({y, rtag, err, lat} !== {ey, tag, eerr, elat}) begin
            errors++;
            $display("FAIL rand_rsp #%0d dut%0d op=%h: got y=%h tag=%0d err=%b lat=%0d want y=%h tag=%0d err=%b lat=%0d",
                     i, s, op, y, rtag, err, lat, ey, tag, eerr, elat);
         end
         checks++;
         if ({alu_v, st_ok, cr_ok} !== {exp_alu[s], 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rand_hold #%0d dut%0d: got alu=%h stable=%b rdy_ok=%b want alu=%h stable=1 rdy_ok=1",
                     i, s, alu_v, st_ok, cr_ok, exp_alu[s]);
         end
         checks++;
         if (get_cnt(s) !== exp_cnt[s]) begin
            errors++; $display("FAIL rand_count #%0d dut%0d: got %0d want %0d", i, s, get_cnt(s), exp_cnt[s]);
         end
      end
   endtask

   task automatic test_back_to_back(input int sel);
      int acc[$]; int cyc; int hs; int g; bit gaps_ok;
      cmd_valid[sel] = 1'b1; cmd_a[sel] = 4'h9; cmd_b[sel] = 4'h4; cmd_op[sel] = 4'd7; cmd_tag[sel] = 2'd0;
      rsp_ready[sel] = 1'b1;
      cyc = 0; hs = 0;
      while (cyc < 100) begin
         if (rsp_valid_o[sel]) hs++;
         if (cmd_ready_o[sel]) acc.push_back(cyc);
         @(posedge clk); #1;
         cyc++;
         if (acc.size() == 4) break;
      end
      cmd_valid[sel] = 1'b0;
      g = 0;
      while (!cmd_ready_o[sel] && g < 50) begin
         if (rsp_valid_o[sel]) hs++;
         @(posedge clk); #1;
         g++;
      end
      rsp_ready[sel] = 1'b0;
      exp_alu[sel] = {4'h9, 4'h4, 4'd7};
      exp_cnt[sel] = (exp_cnt[sel] + 4) & cmask(sel);
      gaps_ok = (acc.size() == 4);
      for (int i = 1; i < acc.size(); i++)
         if (acc[i] - acc[i-1] != lat_of(sel) + 3) gaps_ok = 1'b0;
      checks++;
      if ({gaps_ok, hs} !== {1'b1, 32'd4}) begin
         errors++; $display("FAIL b2b dut%0d: got gaps_ok=%b accepts=%0d handshakes=%0d want gaps of %0d, 4 accepts, 4 handshakes",
                            sel, gaps_ok, acc.size(), hs, lat_of(sel) + 3);
      end
      checks++;
      if (get_cnt(sel) !== exp_cnt[sel]) begin
         errors++; $display("FAIL b2b_count dut%0d: got %0d want %0d", sel, get_cnt(sel), exp_cnt[sel]);
      end
   endtask

   task automatic test_wrap();
      int lat; logic [7:0] y; logic [1:0] rtag; logic err; logic [11:0] alu_v; bit cr_ok; bit st_ok;
      int n;
      n = 8 - exp_cnt[1];
      for (int i = 0; i < n; i++) begin
         run_op(1, 4'h1, 4'h1, 4'd0, 2'd0, 0, 1'b1, lat, y, rtag, err, alu_v, cr_ok, st_ok);
         exp_alu[1] = {4'h1, 4'h1, 4'd0};
         if (i == n - 2) begin
            checks++;
            if (get_cnt(1) !== 7) begin
               errors++; $display("FAIL wrap_top: got %0d want 7", get_cnt(1));
            end
         end
      end
      exp_cnt[1] = 0;
      checks++;
      if (get_cnt(1) !== 0) begin
         errors++; $display("FAIL wrap_zero: got %0d want 0", get_cnt(1));
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         cmd_valid[s] = 1'b0; cmd_a[s] = 4'h0; cmd_b[s] = 4'h0; cmd_op[s] = 4'h0; cmd_tag[s] = 2'd0;
         rsp_ready[s] = 1'b0; exp_cnt[s] = 0; exp_alu[s] = 12'h000;
      end
      test_reset();
      test_directed();
      test_reset_in_wait();
      test_illegal();
      test_random();
      test_back_to_back(0);
      test_back_to_back(1);
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/alu_4_initiator.md
# alu_4_initiator

Command-side master for the `alu_4` combinational ALU. It accepts tagged operation requests over a valid/ready channel and drives registered operands and opcode onto the ALU's A/B/CTRL inputs. After a configurable settling latency it samples the ALU's Y output and returns the result over a valid/ready response channel. It sits between the system command bus and a single `alu_4` instance, with exactly one operation in flight at a time.

## Interface
Parameters:
- `LAT`, default 0, range 0..7: extra cycles between operand drive and Y sample (for a retimed or pipelined ALU path).
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: request valid.
- `cmd_ready` out 1: request accepted when high with `cmd_valid`.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_op` in 4: opcode.
- `cmd_tag` in 2: opaque tag, returned with the response.
- `alu_a` out 4: to ALU A.
- `alu_b` out 4: to ALU B.
- `alu_ctrl` out 4: to ALU CTRL.
- `alu_y` in 8: from ALU Y.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_y` out 8: sampled result.
- `rsp_tag` out 2: tag of the completed request.
- `rsp_err` out 1: illegal opcode flag.
- `op_count` out CNT_W: number of completed responses.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT A, 5 NAND, 6 NOR, 7 XOR, 8 XNOR, 9 MUL.
  - 10..15 are illegal.
- FSM states:
  - IDLE: `cmd_ready`=1. On accept, register `cmd_a`/`cmd_b`/`cmd_op` into `alu_a`/`alu_b`/`alu_ctrl`, latch the tag, load the wait counter with LAT, then go to WAIT.
  - WAIT: decrement the counter. At counter=0, capture `alu_y` into `rsp_y` and go to RESP. With LAT=0, WAIT lasts exactly one cycle.
  - RESP: `rsp_valid`=1. `rsp_y`, `rsp_tag` and `rsp_err` are held stable until the handshake. On handshake, increment `op_count` and go to IDLE.
- `alu_*` hold their last driven value between operations and never glitch back to 0. This gives the combinational ALU stable inputs.
- `op_count` wraps from 2^CNT_W−1 to 0.
- `rst` in any state: return to IDLE, drop `rsp_valid`, discard any in-flight operation.
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0.
  - `alu_a`/`alu_b`/`alu_ctrl`=0.
  - `rsp_y`=0, `rsp_tag`=0, `rsp_err`=0.
  - `op_count`=0.

## Timing
- Accept at edge E. `alu_*` are valid after E. Y is sampled at edge E+1+LAT. `rsp_valid` is high from E+1+LAT.
- Latency from accept to `rsp_valid` is LAT+1 cycles.
- `cmd_ready` is low from E until the cycle after the response handshake. No same-cycle response-to-command overlap.
- Peak throughput is one operation per LAT+3 cycles when `rsp_ready` is held high.
- `rsp_ready` high before `rsp_valid` has no effect.
- `cmd_*` changes while `cmd_ready`=0 are ignored.

## Configuration
- `ALU_INIT_OPCHECK_EN` defined:
  - An accepted opcode ≥10 is not driven; `alu_*` keep their old values.
  - The FSM skips WAIT and goes directly to RESP at E+1 with `rsp_y`=0 and `rsp_err`=1.
  - `op_count` still increments on the handshake.
- `ALU_INIT_OPCHECK_EN` undefined:
  - Every opcode is driven and sampled normally.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `alu_4_pkg`:
  - opcode enum (`OP_ADD`..`OP_MUL`)
  - `OP_LAST`=9
  - FSM state typedef (IDLE/WAIT/RESP)
  - tag width constant
- Single module, no sub-module. The wait counter (3 bits) and the FSM are inline. The `alu_4` instance lives in the parent.

## Test plan
- Reset, then ADD A=5 B=3, LAT=0: response at accept+1 with `rsp_y`=8'h08, tag echoed, `op_count`=1.
- MUL A=F B=F, LAT=3: `rsp_valid` at accept+4, `rsp_y`=8'hE1. `cmd_ready` stays low throughout.
- SUB A=7 B=3 with `rsp_ready` held low for 5 cycles: `rsp_y`=8'h04 stable and `alu_*` unchanged until the handshake.
- AND A=C B=A, then `rst` asserted during WAIT: `rsp_valid` never rises, `cmd_ready`=1 the cycle after reset, all outputs at reset values.
- Op 4'hB with macro on: `rsp_err`=1, `rsp_y`=0 at accept+1, `alu_ctrl` unchanged. With macro off: `alu_ctrl`=4'hB and `rsp_err`=0.
- Force `op_count` to FFFF, complete one operation: `op_count` wraps to 0.
